// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owns the single read/write port of the machine-mode CSR file.
// While IDLE, pipeline CSR accesses pass straight through to the CSR file.
// A synchronous exception or an mret stalls the pipeline. The controller then
// walks the CSR update sequence one access per cycle and finishes with a
// single-cycle PC redirect strobe.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | pass-through of pipeline CSR accesses, events accepted
// T_RDST | trap: read mstatus into the local copy
// T_EPC  | trap: write mepc = aligned excepting PC
// T_CAUSE| trap: write mcause
// T_TVAL | trap: write mtval
// T_WRST | trap: write mstatus (MPIE<-MIE, MIE<-0, MPP<-M)
// T_TVEC | trap: read mtvec, latch the aligned handler address
// M_RDST | mret: read mstatus into the local copy
// M_WRST | mret: write mstatus (MIE<-MPIE, MPIE<-1, MPP<-M)
// M_EPC  | mret: read mepc, latch the aligned return address
// REDIR  | one-cycle redirect strobe, then back to IDLE
module csr_trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] req_rdata,
  input  logic            illegal_valid,
  input  logic            ecall_valid,
  input  logic            ebreak_valid,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_inst,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_read_addr,
  output logic [XLEN-1:0] csr_write_addr,
  output logic [XLEN-1:0] csr_write_data,
  input  logic [XLEN-1:0] csr_read_data
);

  localparam logic [XLEN-1:0] ADDR_MSTATUS = XLEN'(12'h300);
  localparam logic [XLEN-1:0] ADDR_MTVEC   = XLEN'(12'h305);
  localparam logic [XLEN-1:0] ADDR_MEPC    = XLEN'(12'h341);
  localparam logic [XLEN-1:0] ADDR_MCAUSE  = XLEN'(12'h342);
  localparam logic [XLEN-1:0] ADDR_MTVAL   = XLEN'(12'h343);

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_RDST  = 4'd1,
    T_EPC   = 4'd2,
    T_CAUSE = 4'd3,
    T_TVAL  = 4'd4,
    T_WRST  = 4'd5,
    T_TVEC  = 4'd6,
    M_RDST  = 4'd7,
    M_WRST  = 4'd8,
    M_EPC   = 4'd9,
    REDIR   = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            any_event;
  logic            wen_raw;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;
  logic [XLEN-1:0] read_aligned;
  logic [XLEN-1:0] pc_aligned;

  // Derived values: mstatus rewrites for trap entry / mret, aligned addresses.
  always_comb begin
    mstatus_trap        = mstatus_q;
    mstatus_trap[7]     = mstatus_q[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_mret        = mstatus_q;
    mstatus_mret[3]     = mstatus_q[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;

    read_aligned = {csr_read_data[XLEN-1:2], 2'b00};
    pc_aligned   = {pc_q[XLEN-1:2], 2'b00};
    any_event    = illegal_valid | ecall_valid | ebreak_valid | mret_valid;
  end

  // State and latch registers; synchronous reset abandons any sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      mstatus_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      mstatus_q     <= mstatus_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next-state, CSR port steering and handshake outputs.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    mstatus_d      = mstatus_q;
    redirect_pc_d  = redirect_pc_q;
    req_ready      = 1'b0;
    stall          = 1'b1;
    redirect_valid = 1'b0;
    wen_raw        = 1'b0;
    csr_read_addr  = req_addr;
    csr_write_addr = req_addr;
    csr_write_data = req_wdata;

    case (state_q)
      IDLE: begin
        if (any_event) begin
          // The coincident pipeline request is dropped here; the stalled
          // pipeline re-presents it after the redirect.
          pc_d = exc_pc;
          if (illegal_valid) begin
            cause_d = CAUSE_ILLEGAL;
            tval_d  = exc_inst;
            state_d = T_RDST;
          end else if (ecall_valid) begin
            cause_d = CAUSE_ECALL;
            tval_d  = '0;
            state_d = T_RDST;
          end else if (ebreak_valid) begin
            cause_d = CAUSE_EBREAK;
            tval_d  = exc_pc;
            state_d = T_RDST;
          end else begin
            state_d = M_RDST;
          end
        end else begin
          req_ready = 1'b1;
          stall     = 1'b0;
          wen_raw   = req_valid & req_wen;
        end
      end
      T_RDST: begin
        csr_read_addr  = ADDR_MSTATUS;
        csr_write_addr = ADDR_MSTATUS;
        mstatus_d      = csr_read_data;
        state_d        = T_EPC;
      end
      T_EPC: begin
        csr_read_addr  = ADDR_MEPC;
        csr_write_addr = ADDR_MEPC;
        csr_write_data = pc_aligned;
        wen_raw        = 1'b1;
        state_d        = T_CAUSE;
      end
      T_CAUSE: begin
        csr_read_addr  = ADDR_MCAUSE;
        csr_write_addr = ADDR_MCAUSE;
        csr_write_data = cause_q;
        wen_raw        = 1'b1;
        state_d        = T_TVAL;
      end
      T_TVAL: begin
        csr_read_addr  = ADDR_MTVAL;
        csr_write_addr = ADDR_MTVAL;
        csr_write_data = tval_q;
        wen_raw        = 1'b1;
        state_d        = T_WRST;
      end
      T_WRST: begin
        csr_read_addr  = ADDR_MSTATUS;
        csr_write_addr = ADDR_MSTATUS;
        csr_write_data = mstatus_trap;
        wen_raw        = 1'b1;
        state_d        = T_TVEC;
      end
      T_TVEC: begin
        // Vectored mode is meaningless without interrupts, so the mode bits
        // are simply masked off.
        csr_read_addr  = ADDR_MTVEC;
        csr_write_addr = ADDR_MTVEC;
        redirect_pc_d  = read_aligned;
        state_d        = REDIR;
      end
      M_RDST: begin
        csr_read_addr  = ADDR_MSTATUS;
        csr_write_addr = ADDR_MSTATUS;
        mstatus_d      = csr_read_data;
        state_d        = M_WRST;
      end
      M_WRST: begin
        csr_read_addr  = ADDR_MSTATUS;
        csr_write_addr = ADDR_MSTATUS;
        csr_write_data = mstatus_mret;
        wen_raw        = 1'b1;
        state_d        = M_EPC;
      end
      M_EPC: begin
        csr_read_addr  = ADDR_MEPC;
        csr_write_addr = ADDR_MEPC;
        redirect_pc_d  = read_aligned;
        state_d        = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset cycle never commits a CSR write, even mid-sequence.
  always_comb begin
    csr_wen     = wen_raw & ~rst;
    req_rdata   = csr_read_data;
    redirect_pc = redirect_pc_q;
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR file attached.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rdata;
  logic        illegal_valid;
  logic        ecall_valid;
  logic        ebreak_valid;
  logic        mret_valid;
  logic [31:0] exc_pc;
  logic [31:0] exc_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_wen;
  logic [31:0] csr_read_addr;
  logic [31:0] csr_write_addr;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;

  int checks = 0;
  int errors = 0;

  csr_trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .illegal_valid(illegal_valid), .ecall_valid(ecall_valid),
    .ebreak_valid(ebreak_valid), .mret_valid(mret_valid),
    .exc_pc(exc_pc), .exc_inst(exc_inst),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_wen(csr_wen), .csr_read_addr(csr_read_addr),
    .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
    .csr_read_data(csr_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CSR file plus write counters.
  logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mscratch = '0;
  logic [31:0] m_mepc = '0, m_mcause = '0, m_mtval = '0;
  int wen_count = 0, cnt_300 = 0, cnt_343 = 0;

  always @(posedge clk) begin
    if (csr_wen) begin
      wen_count <= wen_count + 1;
      case (csr_write_addr)
        32'h300: begin m_mstatus <= csr_write_data; cnt_300 <= cnt_300 + 1; end
        32'h305: m_mtvec <= csr_write_data;
        32'h340: m_mscratch <= csr_write_data;
        32'h341: m_mepc <= csr_write_data;
        32'h342: m_mcause <= csr_write_data;
        32'h343: begin m_mtval <= csr_write_data; cnt_343 <= cnt_343 + 1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_read_data = 32'h0;
    case (csr_read_addr)
      32'h300: csr_read_data = m_mstatus;
      32'h305: csr_read_data = m_mtvec;
      32'h340: csr_read_data = m_mscratch;
      32'h341: csr_read_data = m_mepc;
      32'h342: csr_read_data = m_mcause;
      32'h343: csr_read_data = m_mtval;
      default: csr_read_data = 32'h0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
    illegal_valid = 0; ecall_valid = 0; ebreak_valid = 0; mret_valid = 0;
    exc_pc = 0; exc_inst = 0;
  endtask

  // Plain pass-through write used to set up CSR contents.
  task automatic csr_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0; req_wen = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_valid got %b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redir_pc got %h exp 0", redirect_pc); end
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", csr_wen); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_csrrw();
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = 32'h340; req_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL csrrw_wr_ready got %b exp 1", req_ready); end
    checks++; if (csr_wen !== 1'b1) begin errors++; $display("FAIL csrrw_wr_wen got %b exp 1", csr_wen); end
    checks++; if (csr_write_addr !== 32'h340) begin errors++; $display("FAIL csrrw_wr_addr got %h exp 340", csr_write_addr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL csrrw_wr_stall got %b exp 0", stall); end
    @(negedge clk);
    req_wen = 0; req_wdata = 0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL csrrw_rd_ready got %b exp 1", req_ready); end
    checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL csrrw_rd_data got %h exp deadbeef", req_rdata); end
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL csrrw_rd_wen got %b exp 0", csr_wen); end
    @(negedge clk);
    req_valid = 0;
  endtask

  // ecall with a coincident pipeline write, and a second ecall during T_CAUSE.
  task automatic test_ecall();
    csr_write(32'h305, 32'h80000101);
    csr_write(32'h300, 32'h00001808);
    @(negedge clk);
    ecall_valid = 1; exc_pc = 32'h100;
    req_valid = 1; req_wen = 1; req_addr = 32'h340; req_wdata = 32'h12345678;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ecall_T_stall got %b exp 1", stall); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ecall_T_ready got %b exp 0", req_ready); end
    checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL ecall_T_wen got %b exp 0", csr_wen); end
    @(negedge clk);                         // T+1 T_RDST
    clear_inputs();
    #1;
    checks++; if (csr_wen !== 1'b0 || csr_read_addr !== 32'h300) begin errors++; $display("FAIL ecall_rdst got wen=%b ra=%h exp 0/300", csr_wen, csr_read_addr); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ecall_rdst_ready got %b exp 0", req_ready); end
    @(negedge clk);                         // T+2 T_EPC
    #1;
    checks++; if ({csr_wen, csr_write_addr, csr_write_data} !== {1'b1, 32'h341, 32'h100}) begin errors++; $display("FAIL ecall_mepc got %b %h %h exp 1 341 100", csr_wen, csr_write_addr, csr_write_data); end
    @(negedge clk);                         // T+3 T_CAUSE, second ecall ignored
    ecall_valid = 1; exc_pc = 32'h999;
    #1;
    checks++; if ({csr_wen, csr_write_addr, csr_write_data} !== {1'b1, 32'h342, 32'd11}) begin errors++; $display("FAIL ecall_mcause got %b %h %h exp 1 342 b", csr_wen, csr_write_addr, csr_write_data); end
    @(negedge clk);                         // T+4 T_TVAL
    clear_inputs();
    #1;
    checks++; if ({csr_wen, csr_write_addr, csr_write_data} !== {1'b1, 32'h343, 32'h0}) begin errors++; $display("FAIL ecall_mtval got %b %h %h exp 1 343 0", csr_wen, csr_write_addr, csr_write_data); end
    @(negedge clk);                         // T+5 T_WRST
    #1;
    checks++; if ({csr_wen, csr_write_addr, csr_write_data} !== {1'b1, 32'h300, 32'h1880}) begin errors++; $display("FAIL ecall_mstatus got %b %h %h exp 1 300 1880", csr_wen, csr_write_addr, csr_write_data); end
    @(negedge clk);                         // T+6 T_TVEC
    #1;
    checks++; if (csr_wen !== 1'b0 || csr_read_addr !== 32'h305 || redirect_valid !== 1'b0) begin errors++; $display("FAIL ecall_tvec got wen=%b ra=%h rv=%b exp 0/305/0", csr_wen, csr_read_addr, redirect_valid); end
    @(negedge clk);                         // T+7 REDIR
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000100) begin errors++; $display("FAIL ecall_redir got %b %h exp 1 80000100", redirect_valid, redirect_pc); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ecall_redir_stall got %b exp 1", stall); end
    @(negedge clk);                         // T+8 IDLE
    #1;
    checks++; if (stall !== 1'b0 || redirect_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ecall_done got stall=%b rv=%b rdy=%b exp 0/0/1", stall, redirect_valid, req_ready); end
    checks++; if (redirect_pc !== 32'h80000100) begin errors++; $display("FAIL ecall_pc_hold got %h exp 80000100", redirect_pc); end
    checks++; if (m_mscratch !== 32'hDEADBEEF) begin errors++; $display("FAIL ecall_req_dropped got %h exp deadbeef", m_mscratch); end
    checks++; if (m_mepc !== 32'h100) begin errors++; $display("FAIL ecall_mepc_final got %h exp 100", m_mepc); end
  endtask

  // illegal wins over a simultaneous ecall; mstatus now 0x1880 so MPIE <- 0.
  task automatic test_illegal_ecall();
    @(negedge clk);
    illegal_valid = 1; ecall_valid = 1; exc_pc = 32'h204; exc_inst = 32'hFFFFFFFF;
    @(negedge clk);
    clear_inputs();
    repeat (6) @(negedge clk);              // through REDIR
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000100) begin errors++; $display("FAIL illegal_redir got %b %h exp 1 80000100", redirect_valid, redirect_pc); end
    checks++; if (m_mcause !== 32'd2) begin errors++; $display("FAIL illegal_mcause got %h exp 2", m_mcause); end
    checks++; if (m_mtval !== 32'hFFFFFFFF) begin errors++; $display("FAIL illegal_mtval got %h exp ffffffff", m_mtval); end
    checks++; if (m_mepc !== 32'h204) begin errors++; $display("FAIL illegal_mepc got %h exp 204", m_mepc); end
    checks++; if (m_mstatus !== 32'h1800) begin errors++; $display("FAIL illegal_mstatus got %h exp 1800", m_mstatus); end
    @(negedge clk);
  endtask

  task automatic test_mret();
    int wc0;
    csr_write(32'h300, 32'h00001880);
    csr_write(32'h341, 32'h00000206);
    @(negedge clk);
    mret_valid = 1; exc_pc = 32'h500;
    wc0 = wen_count;
    #1;
    checks++; if (stall !== 1'b1 || csr_wen !== 1'b0) begin errors++; $display("FAIL mret_T got stall=%b wen=%b exp 1/0", stall, csr_wen); end
    @(negedge clk);                         // T+1 M_RDST
    clear_inputs();
    #1;
    checks++; if (csr_wen !== 1'b0 || csr_read_addr !== 32'h300) begin errors++; $display("FAIL mret_rdst got wen=%b ra=%h exp 0/300", csr_wen, csr_read_addr); end
    @(negedge clk);                         // T+2 M_WRST
    #1;
    checks++; if ({csr_wen, csr_write_addr, csr_write_data} !== {1'b1, 32'h300, 32'h1888}) begin errors++; $display("FAIL mret_mstatus got %b %h %h exp 1 300 1888", csr_wen, csr_write_addr, csr_write_data); end
    @(negedge clk);                         // T+3 M_EPC
    #1;
    checks++; if (csr_wen !== 1'b0 || csr_read_addr !== 32'h341) begin errors++; $display("FAIL mret_epc got wen=%b ra=%h exp 0/341", csr_wen, csr_read_addr); end
    @(negedge clk);                         // T+4 REDIR
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204 || stall !== 1'b1) begin errors++; $display("FAIL mret_redir got %b %h stall=%b exp 1 204 1", redirect_valid, redirect_pc, stall); end
    @(negedge clk);
    #1;
    checks++; if (wen_count - wc0 !== 1) begin errors++; $display("FAIL mret_wen_pulses got %0d exp 1", wen_count - wc0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mret_done_stall got %b exp 0", stall); end
  endtask

  // ebreak with a misaligned PC: mepc aligned, mtval keeps the raw PC.
  task automatic test_ebreak();
    @(negedge clk);
    ebreak_valid = 1; exc_pc = 32'h307;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);                         // T+2
    #1;
    checks++; if (csr_write_data !== 32'h304 || csr_write_addr !== 32'h341) begin errors++; $display("FAIL ebreak_mepc got %h %h exp 341 304", csr_write_addr, csr_write_data); end
    @(negedge clk);                         // T+3
    #1;
    checks++; if (csr_write_data !== 32'd3) begin errors++; $display("FAIL ebreak_mcause got %h exp 3", csr_write_data); end
    @(negedge clk);                         // T+4
    #1;
    checks++; if (csr_write_data !== 32'h307) begin errors++; $display("FAIL ebreak_mtval got %h exp 307", csr_write_data); end
    @(negedge clk);                         // T+5, mstatus was 0x1888
    #1;
    checks++; if (csr_write_data !== 32'h1880) begin errors++; $display("FAIL ebreak_mstatus got %h exp 1880", csr_write_data); end
    repeat (3) @(negedge clk);
  endtask

  // Reset during T_CAUSE: sequence dropped, pass-through immediately usable.
  task automatic test_reset_mid();
    int c300, c343;
    @(negedge clk);
    ecall_valid = 1; exc_pc = 32'h400;
    @(negedge clk);                         // T+1
    clear_inputs();
    c300 = cnt_300; c343 = cnt_343;
    @(negedge clk);                         // T+2
    @(negedge clk);                         // T+3
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (stall !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got stall=%b rv=%b exp 0/0", stall, redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %h exp 0", redirect_pc); end
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = 32'h340; req_wdata = 32'hA5A5A5A5;
    #1;
    checks++; if (req_ready !== 1'b1 || csr_wen !== 1'b1) begin errors++; $display("FAIL rstmid_pass got rdy=%b wen=%b exp 1/1", req_ready, csr_wen); end
    @(negedge clk);
    req_wen = 0;
    #1;
    checks++; if (req_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rstmid_rdata got %h exp a5a5a5a5", req_rdata); end
    @(negedge clk);
    req_valid = 0;
    repeat (8) @(negedge clk);
    checks++; if (cnt_343 - c343 !== 0 || cnt_300 - c300 !== 0) begin errors++; $display("FAIL rstmid_writes got 343:%0d 300:%0d exp 0/0", cnt_343 - c343, cnt_300 - c300); end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_ecall();
    test_illegal_ecall();
    test_mret();
    test_ebreak();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
